uart_tx: RTL and testbench

UART transmitter that serialises one byte per frame onto the line driven into uart_rx on the peer side. It runs on the 3125 kHz clock at 230400 baud, with each bit held for 14 clocks.

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 38 +++
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART constants, FSM state encoding and parity helper.
// The receiver imports the same definitions.
package uart_tx_pkg;

  localparam int CLKS_PER_BIT_DEF = 14;
  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS       = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Even parity: the parity bit makes the total number of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and
// flags the last cycle of each bit period with wrap.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap = en && (cnt_q == LAST) && !clr;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits MSB first, even parity, stop bit.
// Every output is a flop; tx falls on the same edge that accepts tx_start.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk_3125,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud_clr;
  logic                 baud_en;
  logic                 baud_wrap;

  assign baud_en = (state_q != ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk  (clk_3125),
    .rst  (rst),
    .clr  (baud_clr),
    .en   (baud_en),
    .wrap (baud_wrap)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    baud_clr  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          shift_d   = tx_data;
          parity_d  = even_parity(tx_data);
          bit_cnt_d = '0;
          state_d   = ST_START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          baud_clr  = 1'b1;
        end
      end
      ST_START: begin
        if (baud_wrap) begin
          state_d = ST_DATA;
          tx_d    = shift_q[DATA_BITS-1];
        end
      end
      ST_DATA: begin
        if (baud_wrap) begin
          // The shift register always presents the bit in flight at its MSB.
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_PARITY;
            tx_d    = parity_q;
          end else begin
            tx_d = shift_q[DATA_BITS-2];
          end
        end
      end
      ST_PARITY: begin
        if (baud_wrap) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_wrap) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Payload holds no control meaning, so it is left out of reset.
  always_ff @(posedge clk_3125) begin
    shift_q  <= shift_d;
    parity_q <= parity_d;
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a line
// monitor decodes each frame mid-bit and compares against a frame model.
module tb_uart_tx;

  localparam int CPB       = 14;
  localparam int FRAME_LEN = 11 * CPB;

  logic       clk_3125 = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int total = 0;
  int bad   = 0;
  int pushed = 0;
  int aborted = 0;
  int frames_seen = 0;
  logic [7:0] exp_q[$];

  // monitor state
  logic        in_frame = 1'b0;
  int          idx = 0;
  logic [10:0] got;
  logic [7:0]  exp_b;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_3125 (clk_3125),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk_3125 = ~clk_3125;

  // Frame in time order: index 0 = start bit, 1..8 = data MSB first, 9 = parity, 10 = stop.
  function automatic logic [10:0] model_frame(input int b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = ((b >> (7 - i)) & 1) != 0;
      ones  += (b >> i) & 1;
    end
    f[9]  = (ones % 2) == 1;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Line monitor / scoreboard consumer
  initial begin : monitor
    forever begin
      @(negedge clk_3125);
      if (rst) begin
        if (in_frame) begin
          in_frame = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        check("reset_outputs", {tx, tx_busy, tx_done}, 3'b100);
      end else begin
        if (!in_frame && tx_busy) begin
          in_frame = 1'b1;
          idx      = 0;
          got      = '1;
        end
        if (in_frame) begin
          if (tx_busy) begin
            if (idx % CPB == CPB / 2 && idx < FRAME_LEN) got[idx / CPB] = tx;
            check("no_early_done", tx_done, 0);
            idx++;
          end else begin
            check("frame_len", idx, FRAME_LEN);
            check("done_pulse", tx_done, 1);
            check("line_high_after_stop", tx, 1);
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 1, 0);
            end else begin
              exp_b = exp_q.pop_front();
              check("frame_bits", got, model_frame(exp_b));
              frames_seen++;
            end
            in_frame = 1'b0;
          end
        end else begin
          check("idle_line", {tx, tx_done}, 2'b10);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk_3125);
    while (tx_busy && n < 400) begin
      @(negedge clk_3125);
      n++;
    end
    if (tx_busy) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk_3125);
    while (!tx_done && n < 400) begin
      @(negedge clk_3125);
      n++;
    end
    if (!tx_done) check("done_timeout", 1, 0);
  endtask

  task automatic send_pulse(input logic [7:0] b);
    wait_idle();
    tx_start = 1'b1;
    tx_data  = b;
    exp_q.push_back(b);
    pushed++;
    @(negedge clk_3125);
    tx_start = 1'b0;
  endtask

  initial begin : stimulus
    logic [7:0] b2b[4];
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'hA5; b2b[3] = 8'h3F;
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk_3125);
    check("reset_tx", tx, 1);
    check("reset_busy", tx_busy, 0);
    @(posedge clk_3125);
    #2 rst = 1'b0;

    send_pulse(8'h41);
    send_pulse(8'h07);

    // back-to-back with tx_start held high
    wait_idle();
    tx_start = 1'b1;
    tx_data  = b2b[0];
    exp_q.push_back(b2b[0]);
    pushed++;
    for (int i = 1; i < 4; i++) begin
      wait_done();
      tx_data = b2b[i];
      exp_q.push_back(b2b[i]);
      pushed++;
    end
    @(negedge clk_3125);
    tx_start = 1'b0;

    // request while busy is dropped
    send_pulse(8'h41);
    repeat (29) @(negedge clk_3125);
    tx_start = 1'b1;
    tx_data  = 8'h55;
    @(negedge clk_3125);
    tx_start = 1'b0;

    // reset mid-frame
    send_pulse(8'h5A);
    repeat (59) @(posedge clk_3125);
    #2 rst = 1'b1;
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_busy", tx_busy, 0);
    check("midreset_done", tx_done, 0);
    aborted++;
    repeat (3) @(posedge clk_3125);
    #2 rst = 1'b0;
    send_pulse(8'hC3);

    // tx_data change after acceptance
    wait_idle();
    tx_start = 1'b1;
    tx_data  = 8'h41;
    exp_q.push_back(8'h41);
    pushed++;
    @(negedge clk_3125);
    tx_start = 1'b0;
    tx_data  = 8'hBE;

    for (int i = 0; i < 8; i++) begin
      send_pulse(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 5)) @(negedge clk_3125);
    end

    wait_idle();
    repeat (5) @(negedge clk_3125);
    check("queue_empty", exp_q.size(), 0);
    check("frames_seen", frames_seen, pushed - aborted);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
